// File: rtl/v_lsu_agu_if.sv
// Vector LSU address-generator port bundle: op request, stall, and per-bank beat outputs.
// Latency: pure wiring; the AGU behind it presents the first beat one cycle after start.
// Backpressure: mem_stall from the master freezes the slave's current beat in place.
interface v_lsu_agu_if #(
  parameter int AW = 16,
  parameter int SW = 32
);
  localparam int RW = AW - 4;

  // op request side
  logic          start;
  logic          is_store;
  logic          strided;
  logic [1:0]    sew;
  logic [2:0]    lmul;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] stride;
  logic          mem_stall;

  // beat side
  logic [RW-1:0] bank_addr0;
  logic [RW-1:0] bank_addr1;
  logic [RW-1:0] bank_addr2;
  logic [RW-1:0] bank_addr3;
  logic [3:0]    bank_be0;
  logic [3:0]    bank_be1;
  logic [3:0]    bank_be2;
  logic [3:0]    bank_be3;
  logic          bank_we;
  logic [1:0]    rot;
  logic          beat_valid;
  logic          beat_last;
  logic [6:0]    beat_idx;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, is_store, strided, sew, lmul, base_addr, stride, mem_stall,
    input  bank_addr0, bank_addr1, bank_addr2, bank_addr3,
    input  bank_be0, bank_be1, bank_be2, bank_be3,
    input  bank_we, rot, beat_valid, beat_last, beat_idx, busy, done, err
  );

  modport slave (
    input  start, is_store, strided, sew, lmul, base_addr, stride, mem_stall,
    output bank_addr0, bank_addr1, bank_addr2, bank_addr3,
    output bank_be0, bank_be1, bank_be2, bank_be3,
    output bank_we, rot, beat_valid, beat_last, beat_idx, busy, done, err
  );
endinterface

// File: rtl/v_lsu_agu.sv
// Vector load/store AGU: sequences unit-stride or strided beats onto four word-interleaved banks.
// Latency: first beat registered 1 cycle after start; done/err pulse 1 cycle after the final beat.
// Backpressure: mem_stall holds the current beat and all outputs stable; no advance while high.
// Optional misalignment abort is compiled in with V_AGU_MISALIGN_CHK_EN.
module v_lsu_agu #(
  parameter int AW = 16,
  parameter int SW = 32
) (
  input logic        clk,
  input logic        nrst,
  v_lsu_agu_if.slave bus
);
  localparam int RW = AW - 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic [3:0][RW-1:0] addr;
    logic [3:0][3:0]    be;
    logic [1:0]         rot;
    logic               last;
    logic               mis;
  } beat_t;

  // Build one beat from the op shape, the beat address and the beat index.
  // Unit-stride ops keep the base in 'a' for the whole op; strided ops pass the running element address.
  function automatic beat_t gen_beat(input logic          strd,
                                     input logic [1:0]    sew_i,
                                     input logic [2:0]    lmul_i,
                                     input logic [AW-1:0] a,
                                     input logic [6:0]    idx);
    beat_t         r;
    logic [3:0]    lb;    // log2 of total op bits
    logic [3:0]    ls;    // log2 of element bits
    logic [6:0]    n_m1;
    logic [RW-1:0] row;
    logic [1:0]    off;
    logic [1:0]    lane;
    r = '0;
    case (lmul_i)
      3'b000:  lb = 4'd7;
      3'b001:  lb = 4'd8;
      3'b010:  lb = 4'd9;
      3'b111:  lb = 4'd6;
      default: lb = 4'd5;
    endcase
    case (sew_i)
      2'b00:   ls = 4'd3;
      2'b01:   ls = 4'd4;
      default: ls = 4'd5;
    endcase
    off  = a[3:2];
    lane = 2'd0;
    if (strd) begin
      n_m1 = 7'((8'd1 << (lb - ls)) - 8'd1);
      row  = a[AW-1:4];
      for (int b = 0; b < 4; b++) r.addr[b] = row;
      case (sew_i)
        2'b00:   r.be[off] = 4'b0001 << a[1:0];
        2'b01:   r.be[off] = 4'b0011 << {a[1], 1'b0};
        default: r.be[off] = 4'hF;
      endcase
`ifdef V_AGU_MISALIGN_CHK_EN
      r.mis = (sew_i == 2'b01) ? a[0] : (sew_i[1] ? (|a[1:0]) : 1'b0);
`endif
    end else begin
      n_m1 = (lb >= 4'd7) ? 7'((8'd1 << (lb - 4'd7)) - 8'd1) : 7'd0;
      row  = a[AW-1:4] + RW'(idx);
      for (int b = 0; b < 4; b++) begin
        // banks below the start word already belong to the next 16-byte row
        lane      = 2'(b) - off;
        r.addr[b] = (2'(b) < off) ? row + RW'(1) : row;
        case (lb)
          4'd5:    r.be[b] = (lane == 2'd0) ? 4'hF : 4'h0;
          4'd6:    r.be[b] = (lane < 2'd2) ? 4'hF : 4'h0;
          default: r.be[b] = 4'hF;
        endcase
      end
`ifdef V_AGU_MISALIGN_CHK_EN
      r.mis = |a[1:0];
`endif
    end
    r.rot  = off;
    r.last = (idx == n_m1);
    return r;
  endfunction

  state_t        state_q, state_nxt;
  logic          strided_q, is_store_q;
  logic [1:0]    sew_q;
  logic [2:0]    lmul_q;
  logic [AW-1:0] stride_q;
  logic [AW-1:0] acc_q;
  logic [6:0]    idx_q;

  logic          ld, adv;
  logic          c_strided, c_is_store;
  logic [1:0]    c_sew;
  logic [2:0]    c_lmul;
  logic [AW-1:0] c_addr;
  logic [6:0]    c_idx;
  beat_t         nb;

  logic [3:0][RW-1:0] addr_q;
  logic [3:0][3:0]    be_q;
  logic [1:0]         rot_q;
  logic               we_q, run_q, last_q, done_q;
  logic [6:0]         bidx_q;

  // Address arithmetic is mod 2^AW, so stride bits above AW never matter.
  logic unused_stride_hi;
  assign unused_stride_hi = ^bus.stride[SW-1:AW];

  // Select the source of the next beat (fresh op at start, else captured context) and build it.
  always_comb begin
    ld         = (state_q == S_IDLE) && bus.start;
    c_strided  = ld ? bus.strided  : strided_q;
    c_is_store = ld ? bus.is_store : is_store_q;
    c_sew      = ld ? bus.sew      : sew_q;
    c_lmul     = ld ? bus.lmul     : lmul_q;
    c_idx      = ld ? 7'd0 : idx_q + 7'd1;
    if (ld)
      c_addr = bus.base_addr;
    else if (strided_q)
      c_addr = acc_q + stride_q;
    else
      c_addr = acc_q;
    nb = gen_beat(c_strided, c_sew, c_lmul, c_addr, c_idx);
  end

  // Next-state logic: a beat is accepted on any RUN cycle without mem_stall.
  always_comb begin
    state_nxt = state_q;
    adv       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld) state_nxt = nb.mis ? S_ERR : S_RUN;
      end
      S_RUN: begin
        if (!bus.mem_stall) begin
          if (last_q) begin
            state_nxt = S_DONE;
          end else begin
            adv       = 1'b1;
            state_nxt = nb.mis ? S_ERR : S_RUN;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Capture the op at start; step the element address and index on every accepted beat.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      strided_q  <= 1'b0;
      is_store_q <= 1'b0;
      sew_q      <= 2'b00;
      lmul_q     <= 3'b000;
      stride_q   <= '0;
      acc_q      <= '0;
      idx_q      <= 7'd0;
    end else begin
      if (ld) begin
        strided_q  <= bus.strided;
        is_store_q <= bus.is_store;
        sew_q      <= bus.sew;
        lmul_q     <= bus.lmul;
        stride_q   <= bus.stride[AW-1:0];
      end
      if (ld || adv) begin
        acc_q <= c_addr;
        idx_q <= c_idx;
      end
    end
  end

  // Registered beat outputs: load on a new beat, hold through stalls, clear outside RUN.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q <= '0;
      be_q   <= '0;
      rot_q  <= 2'd0;
      we_q   <= 1'b0;
      run_q  <= 1'b0;
      last_q <= 1'b0;
      bidx_q <= 7'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_nxt == S_DONE);
      if (state_nxt == S_RUN) begin
        run_q <= 1'b1;
        if (ld || adv) begin
          addr_q <= nb.addr;
          be_q   <= nb.be;
          rot_q  <= nb.rot;
          last_q <= nb.last;
          bidx_q <= c_idx;
          we_q   <= c_is_store;
        end
      end else begin
        addr_q <= '0;
        be_q   <= '0;
        rot_q  <= 2'd0;
        we_q   <= 1'b0;
        run_q  <= 1'b0;
        last_q <= 1'b0;
        bidx_q <= 7'd0;
      end
    end
  end

`ifdef V_AGU_MISALIGN_CHK_EN
  logic err_q;

  // One-cycle abort flag, issued instead of done when a beat would be misaligned.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) err_q <= 1'b0;
    else       err_q <= (state_nxt == S_ERR);
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.bank_addr0 = addr_q[0];
  assign bus.bank_addr1 = addr_q[1];
  assign bus.bank_addr2 = addr_q[2];
  assign bus.bank_addr3 = addr_q[3];
  assign bus.bank_be0   = be_q[0];
  assign bus.bank_be1   = be_q[1];
  assign bus.bank_be2   = be_q[2];
  assign bus.bank_be3   = be_q[3];
  assign bus.bank_we    = we_q;
  assign bus.rot        = rot_q;
  assign bus.beat_valid = run_q;
  assign bus.busy       = run_q;
  assign bus.beat_last  = last_q;
  assign bus.beat_idx   = bidx_q;
  assign bus.done       = done_q;
endmodule

// File: doc/v_lsu_agu.md
Name: v_lsu_agu

Overview:
Vector load/store address generator and beat sequencer. It sits directly upstream of the vector LSU data path and drives the four word-interleaved 32-bit data memory banks.
- Accepts one vector memory op per start pulse.
- Sequences unit-stride (16-byte beats) or strided (one element per beat) accesses.
- Emits per-bank row address, byte enables and write strobe, plus lane rotation and beat framing, so the LSU can pack and unpack 512-bit register data.

Parameters:
AW, 16, byte-address width; bank row address is AW-4 bits
SW, 32, stride width in bytes (two's complement)

Ports:
clk  in  1  clock, all state on rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  one-cycle op request; accepted only in IDLE
is_store  in  1  1=store, 0=load; sampled at start
strided  in  1  1=strided op, 0=unit-stride; sampled at start
sew  in  2  element width: 00=8b, 01=16b, 10=32b, 11 treated as 32b
lmul  in  3  000=128b, 001=256b, 010=512b, 111=64b, others=32b total bits
base_addr  in  AW  byte base address (rs1)
stride  in  SW  byte stride (rs2), strided ops only
mem_stall  in  1  hold current beat; no advance
bank_addr0..3  out  AW-4 each  row address per bank
bank_be0..3  out  4 each  byte enables per bank
bank_we  out  1  write strobe (beat_valid & store)
rot  out  2  lane rotation = current address[3:2]
beat_valid  out  1  current bank outputs valid
beat_last  out  1  current beat is final
beat_idx  out  7  beat/element index within op
busy  out  1  high in RUN
done  out  1  one-cycle pulse after last beat accepted
err  out  1  misalign abort flag (optional feature only; else tied 0)

Behaviour:
- Reset (async, nrst=0): state IDLE; all outputs 0; counters 0. Reset during RUN abandons the op: no done pulse, outputs 0 immediately.
- States:
  - IDLE -> RUN on start: capture is_store, strided, sew, lmul, base_addr, stride; index=0.
  - RUN: beat_valid=1. A beat is accepted on a cycle with mem_stall=0. Index advances on acceptance. Last beat accepted -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored. start in the DONE cycle is ignored.
- Total bits B from lmul (128/256/512/64/32).
- Unit-stride:
  - Beats N = max(1, B/128). Beat k: row R = base_addr[AW-1:4] + k. Bank b gets R+1 if b < base_addr[3:2], else R.
  - Full beat: all bank_be = 4'hF.
  - B=64: only logical lanes 0,1 enabled. B=32: only lane 0 enabled. Logical lane = (b - base_addr[3:2]) mod 4. Disabled banks get be=0.
  - base_addr[1:0] is ignored unless the optional feature is compiled in.
- Strided:
  - Elements N = B / SEW (1..64).
  - Element i: A = base_addr + i*stride, truncated mod 2^AW; kept as a running accumulator, no multiplier.
  - Only bank A[3:2] enabled, at row A[AW-1:4].
  - be: SEW8 -> 1<<A[1:0]; SEW16 -> 4'b0011<<{A[1],1'b0}; SEW32 -> 4'hF.
  - Negative strides wrap mod 2^AW.
- rot = A[3:2] of the current beat (unit-stride: base_addr[3:2]).
- beat_last = beat_valid && index==N-1.
- Outputs are registered and hold stable while mem_stall=1.
- Latency: first beat valid the cycle after start. done appears one cycle after the last accepted beat.

Optional Feature:
Macro V_AGU_MISALIGN_CHK_EN.
- Defined: misalignment is checked on every beat before issue.
  - SEW16 with A[0]!=0, SEW32 with A[1:0]!=0, or unit-stride with base_addr[1:0]!=0 is misaligned.
  - On misalignment: beat_valid=0, all be=0, err=1 for one cycle in place of done, then IDLE.
- Undefined: low address bits are forced to zero for be generation; err tied 0.

Test Plan:
- Unit-stride, sew=10, lmul=000, base 0x0100, no stall -> one beat:
  - all banks row 0x010, be F, beat_last=1.
  - done pulses at cycle 2 after start.
- Unit-stride, lmul=001, base 0x0108 -> 2 beats, rot=2:
  - beat0: banks0,1 row 0x011, banks2,3 row 0x010.
  - beat1: banks0,1 row 0x012, banks2,3 row 0x011.
- Strided sew=00, lmul=111, stride=5, base 0 -> 8 beats at A=0,5,...,35:
  - beat1: bank1 row 0, be 4'b0010.
  - beat7: A=35, bank0 row 2, be 4'b1000.
- Strided sew=10, lmul=000, stride=-16, base 0x0040, mem_stall held 3 cycles on beat1:
  - beat1 outputs (row 0x003, bank0) stable during the stall.
  - 4 beats total, ending at row 0x001.
- nrst asserted mid-RUN on beat2 of a 4-beat op:
  - outputs 0 asynchronously, no done.
  - a new start after release begins at index 0.
- With V_AGU_MISALIGN_CHK_EN, strided sew=10, base 0x0002:
  - err=1 one cycle after start, no beat_valid, no done.
